// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word
//                over a valid/ready handshake and shifts it out one bit per
//                clock on q, with a per-bit valid and a first-bit frame marker.
//                Back-to-back words are sent with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             q_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sr_shifted;

    // Head bit of a word: the bit that goes out first.
    function automatic logic head_of(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign last_bit   = (cnt == CNT_LAST);
    // Ready depends only on state/counter so the source may wait on it freely.
    assign load_ready = !rst && ((state == IDLE) || ((state == SHIFT) && last_bit));
    assign accept     = load_valid && load_ready;
    // Move the next bit into the head position; vacated bit is filled with 0.
    assign sr_shifted = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0}
                                         : {1'b0, sr[WIDTH-1:1]};
    assign busy       = (state == SHIFT);

    // Control FSM and output registers: q always reflects the head of the
    // word held in sr, so it is loaded from the value sr is about to take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            q           <= IDLE_LEVEL;
            q_valid     <= 1'b0;
            frame_start <= 1'b0;
        end else if (accept) begin
            // Covers both a load from IDLE and a zero-gap reload on the last bit.
            state       <= SHIFT;
            sr          <= din;
            cnt         <= '0;
            q           <= head_of(din);
            q_valid     <= 1'b1;
            frame_start <= 1'b1;
        end else if (state == SHIFT) begin
            sr          <= sr_shifted;
            frame_start <= 1'b0;
            if (last_bit) begin
                state   <= IDLE;
                cnt     <= '0;
                q       <= IDLE_LEVEL;
                q_valid <= 1'b0;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                q       <= head_of(sr_shifted);
                q_valid <= 1'b1;
            end
        end else begin
            q           <= IDLE_LEVEL;
            q_valid     <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx
//  Description : Self-checking bench for piso_tx (WIDTH=8). One MSB-first and
//                one LSB-first instance share clock, reset and load inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       load_valid = 1'b0;

    logic rdy_m, q_m, qv_m, fs_m, busy_m;
    logic rdy_l, q_l, qv_l, fs_l, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(rdy_m), .q(q_m), .q_valid(qv_m),
        .frame_start(fs_m), .busy(busy_m)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(rdy_l), .q(q_l), .q_valid(qv_l),
        .frame_start(fs_l), .busy(busy_l)
    );

    // Serial sequences are written first-bit-in-bit-7 for readability.
    typedef struct {
        logic [7:0] din;
        logic [7:0] msb_seq;
        logic [7:0] lsb_seq;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_ready);
        chk({tag, " q_m"},     {31'd0, q_m},    32'd0);
        chk({tag, " qv_m"},    {31'd0, qv_m},   32'd0);
        chk({tag, " fs_m"},    {31'd0, fs_m},   32'd0);
        chk({tag, " busy_m"},  {31'd0, busy_m}, 32'd0);
        chk({tag, " rdy_m"},   {31'd0, rdy_m},  {31'd0, exp_ready});
        chk({tag, " q_l"},     {31'd0, q_l},    32'd0);
        chk({tag, " qv_l"},    {31'd0, qv_l},   32'd0);
        chk({tag, " busy_l"},  {31'd0, busy_l}, 32'd0);
        chk({tag, " rdy_l"},   {31'd0, rdy_l},  {31'd0, exp_ready});
    endtask

    // One bit cycle of a frame: q, valid, busy, frame marker and ready.
    task automatic chk_bit(input string tag, input logic em, input logic el,
                           input logic efs, input logic erdy);
        chk({tag, " q_m"},   {31'd0, q_m},    {31'd0, em});
        chk({tag, " q_l"},   {31'd0, q_l},    {31'd0, el});
        chk({tag, " qv_m"},  {31'd0, qv_m},   32'd1);
        chk({tag, " qv_l"},  {31'd0, qv_l},   32'd1);
        chk({tag, " busy"},  {31'd0, busy_m}, 32'd1);
        chk({tag, " fs_m"},  {31'd0, fs_m},   {31'd0, efs});
        chk({tag, " fs_l"},  {31'd0, fs_l},   {31'd0, efs});
        chk({tag, " rdy_m"}, {31'd0, rdy_m},  {31'd0, erdy});
        chk({tag, " rdy_l"}, {31'd0, rdy_l},  {31'd0, erdy});
    endtask

    // Single word from IDLE; din is scrambled right after the accepting edge.
    task automatic send_word(input vec_t v);
        @(negedge clk);
        chk("pre-load ready", {31'd0, rdy_m}, 32'd1);
        din        = v.din;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        din        = ~v.din;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_bit($sformatf("word %0h bit%0d", v.din, k),
                    v.msb_seq[7-k], v.lsb_seq[7-k], (k == 0), (k == 7));
        end
        @(negedge clk);
        chk_idle($sformatf("word %0h after", v.din), 1'b1);
    endtask

    // Two words; the second is presented at the negedge of bit raise_k.
    // raise_k==0 keeps load_valid high throughout (back-to-back source).
    task automatic two_words(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [15:0] mseq, input logic [15:0] lseq,
                             input int raise_k);
        @(negedge clk);
        din        = d0;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        if (raise_k != 0) load_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk_bit($sformatf("pair %0h/%0h bit%0d", d0, d1, k),
                    mseq[15-k], lseq[15-k], (k == 0 || k == 8), (k == 7 || k == 15));
            if (k == raise_k) begin
                din        = d1;
                load_valid = 1'b1;
            end
            if (k == 8) begin
                load_valid = 1'b0;
                din        = 8'h5A;
            end
        end
        @(negedge clk);
        chk_idle($sformatf("pair %0h/%0h after", d0, d1), 1'b1);
    endtask

    initial begin
        vecs[0] = '{din: 8'hA5, msb_seq: 8'hA5, lsb_seq: 8'hA5};
        vecs[1] = '{din: 8'h01, msb_seq: 8'h01, lsb_seq: 8'h80};
        vecs[2] = '{din: 8'hC5, msb_seq: 8'hC5, lsb_seq: 8'hA3};
        vecs[3] = '{din: 8'hF0, msb_seq: 8'hF0, lsb_seq: 8'h0F};
        vecs[4] = '{din: 8'h80, msb_seq: 8'h80, lsb_seq: 8'h01};

        // Asynchronous reset asserted between edges takes effect immediately.
        #2 rst = 1'b1;
        #1;
        chk_idle("reset", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready after reset m", {31'd0, rdy_m}, 32'd1);
        chk("ready after reset l", {31'd0, rdy_l}, 32'd1);

        // Single words from the table.
        for (int i = 0; i < 5; i++) send_word(vecs[i]);

        // Back-to-back with load_valid held high.
        two_words(8'hA5, 8'h3C, 16'hA53C, 16'hA53C, 0);

        // Stall: 8'hFF offered at cnt==3 of 8'h00, accepted only at cnt==7.
        two_words(8'h00, 8'hFF, 16'h00FF, 16'h00FF, 3);

        // Reset in the middle of word 8'hF0 (at cnt==4).
        @(negedge clk);
        din        = 8'hF0;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_bit($sformatf("midrst bit%0d", k), vecs[3].msb_seq[7-k],
                    vecs[3].lsb_seq[7-k], (k == 0), 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        chk_idle("midrst assert", 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle($sformatf("midrst quiet%0d", k), 1'b1);
        end
        send_word('{din: 8'h81, msb_seq: 8'h81, lsb_seq: 8'h81});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock on a single serial line, with a per-bit valid and a first-bit frame marker. It is the transmit end for the team's serial shift chains: its `q` stream feeds a serial-in shift register or deserializer directly. It supports back-to-back words with no idle gap.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on `q` whenever no bit is being sent.

Ports:
- clk  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  source has a word on `din`.
- load_ready  output  1  block can accept a word this cycle.
- q  output  1  serial data out (registered).
- q_valid  output  1  `q` carries a data bit this cycle (registered).
- frame_start  output  1  high with the first bit of each word (registered).
- busy  output  1  high while in SHIFT.

## Operation
- States: IDLE, SHIFT. Internal registers: WIDTH-bit shift register `sr` and bit counter `cnt` (width clog2(WIDTH)).
- Accept: a load occurs on a rising edge where `load_valid && load_ready`. `din` is captured into `sr`, `cnt` is set to 0, and the state becomes SHIFT.
- `load_ready` = !rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)). It is combinational from state and counter only and never depends on `load_valid`.
- SHIFT: on each cycle, `q` = current head bit of `sr` (bit WIDTH-1 if MSB_FIRST, else bit 0), `q_valid`=1, and `frame_start`=1 only when cnt==0. On the edge, `sr` shifts toward the head and `cnt` increments.
- Last bit (cnt==WIDTH-1): if a load is accepted on this edge, the new word is captured, cnt returns to 0, and the state stays SHIFT. This gives a zero-gap back-to-back transfer. Otherwise the state returns to IDLE.
- IDLE: `q`=IDLE_LEVEL, `q_valid`=0, `frame_start`=0, `busy`=0.
- `load_valid` asserted while `load_ready`=0 has no effect. The source must hold its word until ready.
- `din` changes outside an accepting edge are ignored. A word in flight is never corrupted.

## Timing
- Reset (async assert, any time, including mid-word):
  - state=IDLE, `sr`=0, `cnt`=0.
  - `q`=IDLE_LEVEL, `q_valid`=0, `frame_start`=0, `busy`=0, `load_ready`=0.
  - A partially sent word is discarded with no further bits.
- After reset: `load_ready`=1 in the first cycle after `rst` deasserts.
- Latency: a load accepted at edge N places the first bit on `q` in the cycle after edge N. Bit k (k=0..WIDTH-1) is valid in cycle N+1+k.
- Word period: WIDTH cycles. Sustained throughput is one word per WIDTH cycles when the source is always valid.
- Idle-to-idle: a single word occupies exactly WIDTH cycles of `q_valid`=1. `q_valid` falls on the edge after the last bit.
- `frame_start` is high for exactly one cycle per word, coincident with its first bit, including back-to-back words.
- `busy`==`q_valid` at all times.

## Test plan
- Reset check: assert `rst` asynchronously between clock edges; `q`=0, `q_valid`=0, `busy`=0 and `load_ready`=0 immediately. Release `rst`; `load_ready`=1 by the next cycle.
- Single word, WIDTH=8, MSB_FIRST=1: load 8'hA5 at edge N.
  - `q` reads 1,0,1,0,0,1,0,1 in cycles N+1..N+8 with `q_valid`=1.
  - `frame_start`=1 only in cycle N+1.
  - `q_valid`=0 and `load_ready`=1 in cycle N+9.
- Back-to-back: `load_valid` held high with 8'hA5 then 8'h3C.
  - 16 contiguous valid bits: 10100101 00111100.
  - `frame_start` pulses in cycles N+1 and N+9.
  - `load_ready` is high only in IDLE and in cycle N+8.
- LSB-first, MSB_FIRST=0: load 8'hA5; `q` reads 1,0,1,0,0,1,0,1 reversed per bit index (bit0 first: 1,0,1,0,0,1,0,1). Repeat with 8'h01 to confirm `q`=1 only in the first bit cycle.
- Stall/ignore: assert `load_valid` with 8'hFF at cnt==3 of a word 8'h00.
  - The 8'h00 word is sent intact.
  - 8'hFF is accepted only at cnt==7 and follows with no gap.
- Reset mid-frame: assert `rst` at cnt==4 of word 8'hF0.
  - Outputs return to reset values immediately and no further bits are sent.
  - After release, a load of 8'h81 is sent correctly from its first bit with `frame_start`=1.
